// File: rtl/mult_div_ctrl.sv
// Sequential signed 32x32 multiplier / 32/32 divider with a HI:LO result.
// MULT uses shift-add over the operand magnitudes; DIV uses restoring
// division. Both take 32 iterations and a final sign-correction cycle.
// DIV by zero skips the iterations and finishes one cycle after start.
module mult_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] mag_a_r, mag_b_r;
  logic        op_r, sign_a_r, sign_b_r, dz_r;
  logic [63:0] work_r;
  logic [4:0]  cnt_r;
  logic        busy_r, done_r, div_zero_r;
  logic [31:0] hi_r, lo_r;

  logic        start_dz_s;
  logic [32:0] mult_sum_s;
  logic [32:0] div_shift_s;
  logic [31:0] div_diff_s;
  logic        div_ge_s;
  logic [63:0] iter_next_s;
  logic [63:0] prod_s;
  logic [31:0] fix_hi_s, fix_lo_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

  assign start_dz_s = op && (b == 32'd0);

  // Next-state logic for IDLE -> RUN/FIX -> IDLE sequencing.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = start_dz_s ? FIX : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 5'd31) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One multiply or divide iteration, selected by the latched op.
  always_comb begin
    mult_sum_s  = {1'b0, work_r[63:32]} + (mag_b_r[cnt_r] ? {1'b0, mag_a_r} : 33'd0);
    // Dividend bits enter the remainder MSB-first while the quotient shifts in below.
    div_shift_s = {work_r[63:32], mag_a_r[5'd31 - cnt_r]};
    div_ge_s    = (div_shift_s >= {1'b0, mag_b_r});
    div_diff_s  = div_shift_s[31:0] - mag_b_r;
    if (op_r) begin
      if (div_ge_s) begin
        iter_next_s = {div_diff_s, work_r[30:0], 1'b1};
      end else begin
        iter_next_s = {div_shift_s[31:0], work_r[30:0], 1'b0};
      end
    end else begin
      iter_next_s = {mult_sum_s, work_r[31:1]};
    end
  end

  // Sign correction of the unsigned result, plus the divide-by-zero result.
  always_comb begin
    prod_s   = (sign_a_r ^ sign_b_r) ? (~work_r + 64'd1) : work_r;
    fix_hi_s = prod_s[63:32];
    fix_lo_s = prod_s[31:0];
    if (dz_r) begin
      fix_hi_s = sign_a_r ? neg32(mag_a_r) : mag_a_r;
      fix_lo_s = 32'hFFFF_FFFF;
    end else if (op_r) begin
      fix_lo_s = (sign_a_r ^ sign_b_r) ? neg32(work_r[31:0]) : work_r[31:0];
      fix_hi_s = sign_a_r ? neg32(work_r[63:32]) : work_r[63:32];
    end else begin
      fix_hi_s = prod_s[63:32];
      fix_lo_s = prod_s[31:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_a_r    <= 32'd0;
      mag_b_r    <= 32'd0;
      op_r       <= 1'b0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      dz_r       <= 1'b0;
      work_r     <= 64'd0;
      cnt_r      <= 5'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mag_a_r  <= abs32(a);
            mag_b_r  <= abs32(b);
            op_r     <= op;
            sign_a_r <= a[31];
            sign_b_r <= b[31];
            dz_r     <= start_dz_s;
            work_r   <= 64'd0;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b1;
            if (!start_dz_s) begin
              div_zero_r <= 1'b0;
            end
          end
        end
        RUN: begin
          work_r <= iter_next_s;
          cnt_r  <= cnt_r + 5'd1;
        end
        FIX: begin
          hi_r       <= fix_hi_s;
          lo_r       <= fix_lo_s;
          div_zero_r <= dz_r;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
